// File: rtl/rf_dump_reader.sv
// Debug walker over the register file read port, streaming {idx,data} entries.
// Optional RF_DUMP_CHANGED_ONLY_EN: emit only registers changed since last dump.
module rf_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_e;

  localparam logic [4:0] FIRST = FIRST_REG[4:0];
  localparam logic [4:0] LAST  = LAST_REG[4:0];

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  sel_q, sel_d;
  logic        vld_q, vld_d;
  logic [4:0]  oidx_q, oidx_d;
  logic [31:0] odata_q, odata_d;
  logic        skip;
  logic [4:0]  idx_nx;

  assign idx_nx = idx_q + 5'd1;

`ifdef RF_DUMP_CHANGED_ONLY_EN
  // Mirror of the last value handed to the consumer for each register.
  logic [31:0] shadow_q [32];

  assign skip = (reg_data == shadow_q[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (state_q == SEND && out_ready) begin
      shadow_q[oidx_q] <= odata_q;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST;
          sel_d   = FIRST;
          state_d = READ;
        end
      end
      READ: begin
        if (skip) begin
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d = idx_nx;
            sel_d = idx_nx;
          end
        end else begin
          odata_d = reg_data;
          oidx_d  = idx_q;
          vld_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          vld_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_nx;
            sel_d   = idx_nx;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign reg_sel   = sel_q;
  assign out_valid = vld_q;
  assign out_idx   = oidx_q;
  assign out_data  = odata_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: full range instance plus a single-register
// instance (FIRST_REG=LAST_REG=5); changed-only cases under RF_DUMP_CHANGED_ONLY_EN.
module tb_rf_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic        busy, done, out_valid;
  logic [4:0]  reg_sel, out_idx;
  logic [31:0] reg_data, out_data;

  logic        start1, out_ready1;
  logic        busy1, done1, out_valid1;
  logic [4:0]  reg_sel1, out_idx1;
  logic [31:0] reg_data1, out_data1;

  logic [31:0] rf [32];

  assign reg_data  = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];
  assign reg_data1 = (reg_sel1 == 5'd0) ? 32'd0 : rf[reg_sel1];

  rf_dump_reader u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  rf_dump_reader #(
    .FIRST_REG (5),
    .LAST_REG  (5)
  ) u_one (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .busy      (busy1),
    .done      (done1),
    .reg_sel   (reg_sel1),
    .reg_data  (reg_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_idx   (out_idx1),
    .out_data  (out_data1)
  );

  logic [36:0] q  [$];
  logic [36:0] q1 [$];
  int n_done  = 0;
  int n_done1 = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) q.push_back({out_idx, out_data});
    if (!rst && done) n_done++;
    if (!rst && out_valid1 && out_ready1) q1.push_back({out_idx1, out_data1});
    if (!rst && done1) n_done1++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input bit which, output int cyc);
    cyc = 1;
    while (!(which ? done1 : done) && cyc < 300) begin
      tick;
      cyc++;
    end
    check("done_seen", which ? done1 : done, 1);
  endtask

  task automatic wait_idx(input logic [4:0] k);
    int n;
    n = 0;
    while (!(out_valid && out_idx == k) && n < 200) begin
      tick;
      n++;
    end
    check("reach_idx", {27'd0, out_idx}, {27'd0, k});
  endtask

  task automatic check_full(input int base);
    logic [36:0] e;
    check("full_count", q.size() - base, 32);
    for (int i = 0; i < q.size() - base; i++) begin
      e = q[base + i];
      check($sformatf("idx%0d", i), {27'd0, e[36:32]}, i);
      check($sformatf("dat%0d", i), e[31:0], i * 32'h1111_1111);
    end
  endtask

  int cyc, base, d0, n;
  logic [36:0] e;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    start1 = 1'b0;
    out_ready1 = 1'b1;
    for (int k = 0; k < 32; k++) rf[k] = 32'd0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sel", reg_sel, 0);
    check("rst_oidx", out_idx, 0);
    check("rst_odata", out_data, 0);

    for (int k = 0; k < 32; k++) rf[k] = k * 32'h1111_1111;

    // reset applied while an entry is held in SEND
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("midsend_valid", out_valid, 1);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_sel", reg_sel, 0);
    check("mrst_done", done, 0);
    tick;
    check("mrst_idle", busy, 0);
    out_ready = 1'b1;

`ifndef RF_DUMP_CHANGED_ONLY_EN
    base = q.size();
    d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    run_to_done(0, cyc);
    check("full_done_cyc", cyc, 65);
    check("full_busy_done", busy, 1);
    tick;
    check("full_busy_after", busy, 0);
    check("full_done_after", done, 0);
    check_full(base);
    check("full_ndone", n_done - d0, 1);

    base = q.size();
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_idx(5'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", out_valid, 1);
      check("bp_idx", out_idx, 3);
      check("bp_data", out_data, 32'h3333_3333);
      check("bp_sel", reg_sel, 3);
    end
    out_ready = 1'b1;
    tick;
    check("bp_rel_valid", out_valid, 0);
    tick;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_idx", out_idx, 4);
    check("bp_next_data", out_data, 32'h4444_4444);
    run_to_done(0, cyc);
    tick;
    check_full(base);

    base = q.size();
    d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_idx(5'd10);
    start = 1'b1;
    tick;
    start = 1'b0;
    run_to_done(0, cyc);
    tick;
    check_full(base);
    check("restart_ndone", n_done - d0, 1);
    tick;
    tick;
    check("restart_idle", busy, 0);
    check("restart_ndone2", n_done - d0, 1);
`else
    for (int k = 0; k < 32; k++) rf[k] = 32'd0;
    rf[7] = 32'h1234;
    base = q.size();
    d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    run_to_done(0, cyc);
    tick;
    check("chg1_count", q.size() - base, 1);
    if (q.size() > base) begin
      e = q[base];
      check("chg1_idx", {27'd0, e[36:32]}, 7);
      check("chg1_data", e[31:0], 32'h1234);
    end
    check("chg1_ndone", n_done - d0, 1);

    base = q.size();
    d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    run_to_done(0, cyc);
    tick;
    check("chg2_count", q.size() - base, 0);
    check("chg2_ndone", n_done - d0, 1);
    check("chg2_idle", busy, 0);

    rf[7] = 32'h5;
    base = q.size();
    start = 1'b1;
    tick;
    start = 1'b0;
    run_to_done(0, cyc);
    tick;
    check("chg3_count", q.size() - base, 1);
    if (q.size() > base) begin
      e = q[base];
      check("chg3_idx", {27'd0, e[36:32]}, 7);
      check("chg3_data", e[31:0], 32'h5);
    end
`endif

    rf[5] = 32'hDEAD_BEEF;
    base = q1.size();
    d0 = n_done1;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    run_to_done(1, cyc);
    check("one_done_cyc", cyc, 3);
    tick;
    check("one_busy_after", busy1, 0);
    check("one_count", q1.size() - base, 1);
    if (q1.size() > base) begin
      e = q1[base];
      check("one_idx", {27'd0, e[36:32]}, 5);
      check("one_data", e[31:0], 32'hDEAD_BEEF);
    end
    check("one_ndone", n_done1 - d0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
